apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master_pkg.sv | 25 ++
 rtl/apb_cmd_master.sv | 128 ++++++++++++
 tb/tb_apb_cmd_master.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_cmd_master_pkg.sv
// rtl/apb_cmd_master_pkg.sv - shared APB width macros, timeout default and FSM encoding
// Other files of the APB UART slice pick up widths and state encoding from here.
`ifndef APB_UART_DEFS
`define APB_UART_DEFS
`define APB_ADDR_WIDTH 32
`define APB_DATA_WIDTH 32
`define APB_TIMEOUT 16
`endif

package apb_cmd_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned APB_TIMEOUT_DEFAULT = `APB_TIMEOUT;

  // Wait counter must hold the value TIMEOUT itself; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - single-outstanding command-to-APB master with access timeout
// Commands are taken only in IDLE; each runs SETUP then ACCESS until pready or timeout.
`ifndef APB_UART_DEFS
`define APB_UART_DEFS
`define APB_ADDR_WIDTH 32
`define APB_DATA_WIDTH 32
`define APB_TIMEOUT 16
`endif

module apb_cmd_master
  import apb_cmd_master_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = `APB_ADDR_WIDTH,
  parameter int unsigned APB_DATA_WIDTH = `APB_DATA_WIDTH,
  parameter int unsigned TIMEOUT        = APB_TIMEOUT_DEFAULT
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pready,
  input  logic                      pslverr
);

  localparam int unsigned      CNT_W    = cnt_width(TIMEOUT);
  localparam bit               TO_EN    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  apb_state_e                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      pwrite_q, pwrite_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                      rsp_valid_q, rsp_valid_d;
  logic [APB_DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                      rsp_err_q, rsp_err_d;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d  = ST_SETUP;
          cnt_d    = '0;
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (pready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : prdata;
          rsp_err_d   = pslverr;
        end else begin
          if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
          // This wait cycle brings the count to TIMEOUT: give up with an error.
          if (TO_EN && (cnt_q == CNT_LAST)) begin
            state_d     = ST_IDLE;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready = presetn && (state_q == ST_IDLE);
  assign psel      = (state_q != ST_IDLE);
  assign penable   = (state_q == ST_ACCESS);
  assign pwrite    = pwrite_q;
  assign paddr     = paddr_q;
  assign pwdata    = pwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - self-checking bench for apb_cmd_master
// Transaction-level model builds a per-cycle expectation queue checked on every falling edge.
`timescale 1ns/1ps
module tb_apb_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic          pclk = 1'b0;
  logic          presetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata = '0;
  logic          pready = 1'b0;
  logic          pslverr = 1'b0;

  always #5 pclk = ~pclk;

  apb_cmd_master #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  typedef struct {
    bit            psel;
    bit            pen;
    bit            pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    bit            rspv;
    logic [DW-1:0] rdata;
    bit            err;
  } rec_t;

  rec_t          exp_q[$];
  rec_t          cur;
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_rdata = '0;
  bit            exp_err = 1'b0;
  bit            rsp_pulse = 1'b0;
  bit            noisy = 1'b0;
  int            acc_cnt = 0;
  int            last_acc = 0;
  int            cyc = 0;
  int            rsp_times[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge pclk) cyc++;

  always @(negedge pclk) begin
    if (presetn) begin
      if (psel && penable) acc_cnt++;
      if (rsp_valid) begin
        last_acc = acc_cnt;
        acc_cnt = 0;
        rsp_times.push_back(cyc);
      end
    end
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      chk("psel", psel, cur.psel);
      chk("penable", penable, cur.pen);
      chk("cmd_ready", cmd_ready, !cur.psel);
      chk("rsp_valid", rsp_valid, cur.rspv);
      chk("rsp_rdata", rsp_rdata, cur.rdata);
      chk("rsp_err", rsp_err, cur.err);
      if (cur.psel) begin
        chk("pwrite", pwrite, cur.pwrite);
        chk("paddr", paddr, cur.paddr);
        chk("pwdata", pwdata, cur.pwdata);
      end
    end
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic push(input bit ps, input bit pe, input bit w, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input bit rv);
    rec_t r;
    r.psel = ps; r.pen = pe; r.pwrite = w; r.paddr = a; r.pwdata = d;
    r.rspv = rv; r.rdata = exp_rdata; r.err = exp_err;
    exp_q.push_back(r);
  endtask

  task automatic scramble();
    cmd_valid = 1'($urandom);
    cmd_write = 1'($urandom);
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
    pready    = 1'($urandom);
    pslverr   = 1'($urandom);
    prdata    = $urandom;
  endtask

  task automatic idle_cyc();
    scramble();
    cmd_valid = 1'b0;
    push(0, 0, 0, '0, '0, rsp_pulse);
    rsp_pulse = 1'b0;
    tick();
  endtask

  // Presents one command in the current (idle) cycle and runs it to completion;
  // returns at the start of the response cycle.
  task automatic txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input int waits, input logic [DW-1:0] rd, input bit er);
    bit tmo;
    int n;
    tmo = (TO != 0) && (waits >= TO);
    n = tmo ? TO : waits + 1;
    scramble();
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    push(0, 0, 0, '0, '0, rsp_pulse);
    rsp_pulse = 1'b0;
    tick();
    scramble();
    push(1, 0, w, a, d, 0);
    tick();
    for (int i = 0; i < n; i++) begin
      scramble();
      if (i == waits) begin
        pready = 1'b1; pslverr = er; prdata = rd;
      end else begin
        pready = 1'b0; pslverr = noisy | 1'($urandom);
      end
      push(1, 1, w, a, d, 0);
      tick();
    end
    exp_rdata = (tmo || w) ? '0 : rd;
    exp_err   = tmo ? 1'b1 : er;
    rsp_pulse = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    int wsel;
    int waits;
    repeat (3) @(posedge pclk);
    #1;
    chk("reset psel", psel, 0);
    chk("reset penable", penable, 0);
    chk("reset pwrite", pwrite, 0);
    chk("reset paddr", paddr, 0);
    chk("reset pwdata", pwdata, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_rdata", rsp_rdata, 0);
    chk("reset rsp_err", rsp_err, 0);
    presetn = 1'b1;
    #1;
    chk("release cmd_ready", cmd_ready, 1);

    // zero-wait write
    txn(1, 32'h0C, 32'h5A, 0, '0, 0);
    chk("zw rsp_valid", rsp_valid, 1);
    chk("zw rsp_err", rsp_err, 0);
    idle_cyc();
    chk("zw access cycles", last_acc, 1);

    // read with three wait states
    txn(0, 32'h04, '0, 3, 32'hA5, 0);
    chk("ws rsp_rdata", rsp_rdata, 32'hA5);
    idle_cyc();
    chk("ws access cycles", last_acc, 4);

    // slave never ready
    txn(0, 32'h10, '0, 1000, 32'hFF, 0);
    chk("to rsp_err", rsp_err, 1);
    chk("to rsp_rdata", rsp_rdata, 0);
    chk("to psel", psel, 0);
    idle_cyc();
    chk("to access cycles", last_acc, 16);

    // slave error, then error flag during wait states only
    txn(0, 32'h08, '0, 0, 32'h33, 1);
    chk("slverr rsp_err", rsp_err, 1);
    idle_cyc();
    noisy = 1'b1;
    txn(0, 32'h08, '0, 2, 32'h44, 0);
    chk("ignored slverr", rsp_err, 0);
    noisy = 1'b0;
    idle_cyc();

    // pready on the cycle the count reaches the limit
    txn(0, 32'h18, '0, TO - 1, 32'h66, 0);
    chk("edge rsp_rdata", rsp_rdata, 32'h66);
    idle_cyc();

    // back-to-back
    rsp_times.delete();
    txn(1, 32'h100, 32'h11, 0, '0, 0);
    txn(1, 32'h104, 32'h22, 0, '0, 0);
    idle_cyc();
    chk("b2b spacing", (rsp_times.size() == 2) ? rsp_times[1] - rsp_times[0] : -1, 3);

    // reset during ACCESS
    scramble();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h77;
    push(0, 0, 0, '0, '0, rsp_pulse);
    rsp_pulse = 1'b0;
    tick();
    scramble(); pready = 1'b0;
    push(1, 0, 1, 32'h20, 32'h77, 0);
    tick();
    scramble(); pready = 1'b0;
    push(1, 1, 1, 32'h20, 32'h77, 0);
    tick();
    pready = 1'b0;
    presetn = 1'b0;
    #1;
    chk("arst psel", psel, 0);
    chk("arst penable", penable, 0);
    chk("arst pwrite", pwrite, 0);
    chk("arst paddr", paddr, 0);
    chk("arst pwdata", pwdata, 0);
    chk("arst rsp_valid", rsp_valid, 0);
    chk("arst cmd_ready", cmd_ready, 0);
    tick();
    presetn = 1'b1;
    exp_rdata = '0; exp_err = 1'b0; rsp_pulse = 1'b0; acc_cnt = 0;
    idle_cyc();
    idle_cyc();
    txn(0, 32'h24, '0, 1, 32'hC3, 0);
    chk("post-reset rdata", rsp_rdata, 32'hC3);
    idle_cyc();

    // randomized traffic
    for (int k = 0; k < 60; k++) begin
      wsel = $urandom_range(0, 9);
      if (wsel < 6)       waits = wsel % 4;
      else if (wsel == 6) waits = TO - 2;
      else if (wsel == 7) waits = TO - 1;
      else if (wsel == 8) waits = TO;
      else                waits = $urandom_range(TO + 1, TO + 9);
      txn(1'($urandom), $urandom, $urandom, waits, $urandom, 1'($urandom));
      if ($urandom_range(0, 1) == 1) idle_cyc();
    end
    idle_cyc();
    idle_cyc();
    @(negedge pclk);
    #1;
    chk("queue drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
